// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send,
// 8 data bits LSB first, odd parity, stop, device ack) with a transfer timeout.
// Ports:
//   clk_i, rst_ni           system clock, async active-low reset
//   ps2_clk_i, ps2_data_i   raw PS/2 line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe 1 = pull line low, 0 = release (open-drain)
//   tx_data, tx_write       byte to send, level request held until ack
//   tx_write_ack            one-cycle pulse when tx_data is latched
//   tx_error_no_ack         sticky: last transfer got no ack or timed out
//   busy                    high whenever not idle
// Build option: define PS2_TX_FILTER_EN to add an 8-sample glitch filter on
// the synchronized PS/2 clock before falling-edge detection.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_write_ack,
    output logic       tx_error_no_ack,
    output logic       busy
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // Two-flop synchronizers; idle lines are high so they reset to 1.
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    logic clk_lvl;

`ifdef PS2_TX_FILTER_EN
    // Level follows the synchronizer only after 8 consecutive samples
    // that disagree with it, so short line glitches never reach the FSM.
    logic       clk_flt_q;
    logic [2:0] flt_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_flt_q <= 1'b1;
            flt_cnt_q <= 3'd0;
        end else if (clk_s != clk_flt_q) begin
            if (flt_cnt_q == 3'd7) begin
                clk_flt_q <= clk_s;
                flt_cnt_q <= 3'd0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 3'd1;
            end
        end else begin
            flt_cnt_q <= 3'd0;
        end
    end

    assign clk_lvl = clk_flt_q;
`else
    assign clk_lvl = clk_s;
`endif

    logic clk_prev_q;
    logic clk_fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_lvl;

    state_t        state_q,   state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    frame_q,   frame_d;
    logic          ack_q,     ack_d;
    logic          err_q,     err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= 4'd0;
            frame_q   <= 9'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Bit on the wire in SEND: start (0) before the first falling edge,
    // then data LSB first and parity from frame_q, then stop (1).
    logic tx_bit;

    always_comb begin
        tx_bit = 1'b1;
        if (bit_cnt_q == 4'd0) begin
            tx_bit = 1'b0;
        end else if (bit_cnt_q <= 4'd9) begin
            tx_bit = frame_q[bit_cnt_q - 4'd1];
        end
    end

    always_comb begin
        state_d     = state_q;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        ack_d       = 1'b0;
        err_d       = err_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tx_write) begin
                    frame_d   = {~^tx_data, tx_data};
                    ack_d     = 1'b1;
                    err_d     = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt_q == INH_LAST) begin
                    state_d = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_RTS: begin
                ps2_data_oe = 1'b1;
                bit_cnt_d   = 4'd0;
                to_cnt_d    = '0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                ps2_data_oe = ~tx_bit;
                to_cnt_d    = to_cnt_q + 1'b1;
                if (to_cnt_q == TO_LAST) begin
                    // Release the data line in the same cycle as the abort.
                    ps2_data_oe = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_WAIT_IDLE;
                end else if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_IDLE;
                end else if (clk_fall) begin
                    err_d   = data_s;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_lvl && data_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_write_ack    = ack_q;
    assign tx_error_no_ack = err_q;
    assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed scoreboard bench for ps2_host_tx with an
// open-drain PS/2 device model that clocks, samples, acks or misbehaves.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TO  = 3000;
    localparam int H   = 25;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_STOP   = 2;
    localparam int M_GLITCH = 3;

    localparam int A_NONE   = 0;
    localparam int A_TOGGLE = 1;
    localparam int A_RESET  = 2;

    typedef struct {
        logic [9:0] frame;
        int         nbits;
        bit         err;
        bit         chk_inh;
        bit         chk_to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_write_ack;
    logic       tx_error_no_ack;
    logic       busy;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic line_clk;
    logic line_data;

    assign line_clk  = !(ps2_clk_oe || dev_clk_low);
    assign line_data = !(ps2_data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ps2_clk_i      (line_clk),
        .ps2_data_i     (line_data),
        .ps2_clk_oe     (ps2_clk_oe),
        .ps2_data_oe    (ps2_data_oe),
        .tx_data        (tx_data),
        .tx_write       (tx_write),
        .tx_write_ack   (tx_write_ack),
        .tx_error_no_ack(tx_error_no_ack),
        .busy           (busy)
    );

    int vec = 0;
    int mis = 0;
    exp_t q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [9:0] f, input int nb,
                                input bit er, input bit ti, input bit to);
        exp_t e;
        e.frame   = f;
        e.nbits   = nb;
        e.err     = er;
        e.chk_inh = ti;
        e.chk_to  = to;
        return e;
    endfunction

    // Device model
    int         dev_mode = M_ACK;
    bit         dev_done = 1'b1;
    logic [9:0] cap = '0;
    int         cap_n = 0;

    initial begin
        forever begin
            dev_done = 1'b1;
            while (line_clk) @(posedge clk);
            dev_done = 1'b0;
            cap_n    = 0;
            cap      = '0;
            while (!(line_clk && !line_data)) @(posedge clk);
            repeat (30) @(posedge clk);
            for (int k = 1; k <= 11; k++) begin
                if (dev_mode == M_STOP && k == 5) break;
                if (k == 11 && dev_mode != M_NOACK) begin
                    dev_data_low = 1'b1;
                    repeat (12) @(posedge clk);
                end
                dev_clk_low = 1'b1;
                repeat (H) @(posedge clk);
                dev_clk_low = 1'b0;
                if (k <= 10) begin
                    cap[cap_n] = line_data;
                    cap_n++;
                end
                if (dev_mode == M_GLITCH && k == 3) begin
                    repeat (10) @(posedge clk);
                    dev_clk_low = 1'b1;
                    repeat (3) @(posedge clk);
                    dev_clk_low = 1'b0;
                    repeat (H - 13) @(posedge clk);
                end else begin
                    repeat (H) @(posedge clk);
                end
                dev_data_low = 1'b0;
            end
        end
    end

    // Monitor: checks each transfer when busy falls
    bit busy_p = 1'b0;
    int acks   = 0;
    int inh    = 0;
    int cyc    = 0;
    int rel_at = -1;

    task automatic check_end();
        exp_t e;
        int   dur;
        if (q.size() == 0) begin
            vec++;
            mis++;
            $display("FAIL unexpected_end: got transfer end expected none");
        end else begin
            e = q.pop_front();
            chk("ack_pulses", acks, 1);
            chk("err_flag", tx_error_no_ack, e.err);
            if (e.chk_inh) chk("inhibit_len", inh, INH);
            if (e.nbits > 0) begin
                logic [9:0] m;
                m = 10'((1 << e.nbits) - 1);
                chk("bit_count", cap_n, e.nbits);
                chk("frame", cap & m, e.frame & m);
            end
            if (e.chk_to) begin
                dur = cyc - rel_at;
                vec++;
                if (rel_at < 0 || dur < TO || dur > TO + 20) begin
                    mis++;
                    $display("FAIL timeout_len: got %0d expected %0d..%0d",
                             dur, TO, TO + 20);
                end
            end
        end
        acks = 0;
    endtask

    always @(negedge clk) begin
        if (tx_write_ack) acks++;
        if (busy) begin
            if (!busy_p) begin
                inh    = 0;
                cyc    = 0;
                rel_at = -1;
            end
            cyc++;
            if (ps2_clk_oe) inh++;
            if (ps2_data_oe && !ps2_clk_oe && rel_at < 0) rel_at = cyc;
        end else if (busy_p) begin
            check_end();
        end
        busy_p = busy;
    end

    // Stimulus
    task automatic xfer(input logic [7:0] b, input int mode,
                        input int act, input exp_t e);
        int n;
        dev_mode = mode;
        q.push_back(e);
        tx_data  = b;
        tx_write = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_write_ack && n < 200);
        chk("ack_seen", tx_write_ack, 1);
        tx_write = 1'b0;
        repeat (5) @(negedge clk);
        if (act == A_TOGGLE) begin
            repeat (10) @(negedge clk);
            tx_write = 1'b1;
            repeat (5) @(negedge clk);
            tx_write = 1'b0;
            n = 0;
            while (cap_n < 3 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            tx_write = 1'b1;
            repeat (5) @(negedge clk);
            tx_write = 1'b0;
        end
        if (act == A_RESET) begin
            n = 0;
            while (cap_n < 4 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk("reached_bit5", cap_n >= 4, 1);
            repeat (5) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("rst_clk_oe", ps2_clk_oe, 0);
            chk("rst_data_oe", ps2_data_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", tx_error_no_ack, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        n = 0;
        while ((busy || !dev_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_done", n < 20000, 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        tx_write = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_ack", tx_write_ack, 0);
        chk("reset_err", tx_error_no_ack, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        xfer(8'hED, M_ACK, A_NONE, mk(10'h3ED, 10, 1'b0, 1'b1, 1'b0));
        xfer(8'hF4, M_NOACK, A_NONE, mk(10'h2F4, 10, 1'b1, 1'b1, 1'b0));
        xfer(8'h00, M_STOP, A_NONE, mk(10'h000, 4, 1'b1, 1'b1, 1'b1));
        xfer(8'hFF, M_ACK, A_NONE, mk(10'h3FF, 10, 1'b0, 1'b1, 1'b0));
        xfer(8'h5A, M_ACK, A_RESET, mk(10'h000, 0, 1'b0, 1'b1, 1'b0));
        xfer(8'hAA, M_ACK, A_TOGGLE, mk(10'h3AA, 10, 1'b0, 1'b1, 1'b0));
`ifdef PS2_TX_FILTER_EN
        xfer(8'h3C, M_GLITCH, A_NONE, mk(10'h33C, 10, 1'b0, 1'b1, 1'b0));
`else
        xfer(8'h3C, M_GLITCH, A_NONE, mk(10'h000, 0, 1'b1, 1'b1, 1'b0));
`endif
        chk("pending_expect", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
